// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control bundle and constants for the ID/EX stage
package mips_pkg;

  localparam int REG_W        = 5;
  localparam int REG_DST_W    = 2;
  localparam int MEM_TO_REG_W = 2;
  localparam int OP_W         = 3;
  localparam int DATA_W       = 32;
  localparam int STALL_CNT_W  = 16;

  localparam logic [REG_W-1:0]       ZERO_REG  = '0;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  // Decoded control bundle carried from ID into EX
  typedef struct packed {
    logic [REG_DST_W-1:0]    reg_dst;
    logic [MEM_TO_REG_W-1:0] mem_to_reg;
    logic                    reg_write;
    logic                    alu_src;
    logic                    mem_read;
    logic                    mem_write;
    logic [OP_W-1:0]         operation;
  } ctrl_t;

  // Bubble: every control field inactive
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard detection and PC/IF-ID write enables (HAZARD_DETECT_EN)
module hazard_unit
  import mips_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             freeze_i,
  output logic             hazard_stall_o,
  output logic             pc_write_o,
  output logic             if_id_write_o
);

`ifdef HAZARD_DETECT_EN
  // A load in EX whose destination feeds the decoding instruction; $zero never counts
  assign hazard_stall_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != ZERO_REG) &&
                          ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{ex_valid_i, ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i};
  assign hazard_stall_o = 1'b0;
`endif

  // Upstream holds whenever a bubble is inserted or the whole pipe is frozen
  assign pc_write_o    = !(hazard_stall_o || freeze_i);
  assign if_id_write_o = !(hazard_stall_o || freeze_i);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble/freeze control (HAZARD_DETECT_EN)
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_DST_W-1:0]    id_reg_dst,
  input  logic [MEM_TO_REG_W-1:0] id_mem_to_reg,
  input  logic                    id_reg_write,
  input  logic                    id_alu_src,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic [OP_W-1:0]         id_operation,
  input  logic [DATA_W-1:0]       id_pc4,
  input  logic [DATA_W-1:0]       id_rd1,
  input  logic [DATA_W-1:0]       id_rd2,
  input  logic [DATA_W-1:0]       id_imm,
  input  logic [REG_W-1:0]        id_rs,
  input  logic [REG_W-1:0]        id_rt,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    flush,
  input  logic                    freeze,
  output logic [REG_DST_W-1:0]    ex_reg_dst,
  output logic [MEM_TO_REG_W-1:0] ex_mem_to_reg,
  output logic                    ex_reg_write,
  output logic                    ex_alu_src,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic [OP_W-1:0]         ex_operation,
  output logic [DATA_W-1:0]       ex_pc4,
  output logic [DATA_W-1:0]       ex_rd1,
  output logic [DATA_W-1:0]       ex_rd2,
  output logic [DATA_W-1:0]       ex_imm,
  output logic [REG_W-1:0]        ex_rs,
  output logic [REG_W-1:0]        ex_rt,
  output logic [REG_W-1:0]        ex_rd,
  output logic                    ex_valid,
  output logic                    pc_write,
  output logic                    if_id_write,
  output logic                    hazard_stall,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

  assign id_ctrl = {id_reg_dst, id_mem_to_reg, id_reg_write, id_alu_src,
                    id_mem_read, id_mem_write, id_operation};

  hazard_unit u_hazard (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_rt_i        (rt_q),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .freeze_i       (freeze),
    .hazard_stall_o (hazard_stall),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write)
  );

  // Next state: freeze holds, flush/hazard injects a bubble, otherwise load from ID
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    pc4_d   = pc4_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    if (!freeze) begin
      pc4_d = id_pc4;
      rd1_d = id_rd1;
      rd2_d = id_rd2;
      imm_d = id_imm;
      rs_d  = id_rs;
      rt_d  = id_rt;
      rd_d  = id_rd;
      if (flush || hazard_stall) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = id_ctrl;
        valid_d = 1'b1;
      end
    end
  end

  // Pipeline register; reset clears everything regardless of stall/freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

`ifdef HAZARD_DETECT_EN
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // Count bubbles actually written; a frozen edge writes nothing
  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard_stall && !freeze && (stall_count_q != STALL_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Saturating bubble counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_operation  = ctrl_q.operation;
  assign ex_pc4        = pc4_q;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage, either HAZARD_DETECT_EN build
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, freeze;
  logic [10:0] id_ctrl;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;

  logic [1:0]  ex_reg_dst, ex_mem_to_reg;
  logic        ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_operation;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, pc_write, if_id_write, hazard_stall;
  logic [15:0] stall_count;

  // ctrl packing: {reg_dst[10:9], mem_to_reg[8:7], reg_write 6, alu_src 5, mem_read 4, mem_write 3, op[2:0]}
  localparam logic [10:0] C_LW  = {2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
  localparam logic [10:0] C_ADD = {2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010};
  localparam logic [10:0] C_RWW = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010};

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_reg_dst(id_ctrl[10:9]), .id_mem_to_reg(id_ctrl[8:7]),
    .id_reg_write(id_ctrl[6]), .id_alu_src(id_ctrl[5]),
    .id_mem_read(id_ctrl[4]), .id_mem_write(id_ctrl[3]),
    .id_operation(id_ctrl[2:0]),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .freeze(freeze),
    .ex_reg_dst(ex_reg_dst), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_operation(ex_operation),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  typedef struct {
    logic         valid;
    logic [10:0]  ctrl;
    logic [142:0] data;
    logic         chk;
    logic [15:0]  cnt;
  } exp_t;

  exp_t sb[$];

  logic         m_valid;
  logic [10:0]  m_ctrl;
  logic [142:0] m_data;
  logic         m_chk;
  logic [15:0]  m_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_ctrl = c;
    id_rs   = rs;
    id_rt   = rt;
    id_rd   = rd;
    id_pc4  = $urandom;
    id_rd1  = $urandom;
    id_rd2  = $urandom;
    id_imm  = $urandom;
  endtask

  // One clock: drive, check combinational outputs against the model, push the
  // expected registered state, then pop and compare it after the edge.
  task automatic step(input logic r, input logic fl, input logic fz);
    exp_t         e;
    logic         haz, exp_pw;
    logic [142:0] idd, got_data;
    logic [10:0]  got_ctrl;
    @(negedge clk);
    rst = r; flush = fl; freeze = fz;
    #1;
    idd = {id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd};
`ifdef HAZARD_DETECT_EN
    haz = m_valid && m_ctrl[4] && (m_data[9:5] != 5'd0) &&
          ((m_data[9:5] == id_rs) || (m_data[9:5] == id_rt));
`else
    haz = 1'b0;
`endif
    exp_pw = !(haz || fz);
    check("hazard_stall", hazard_stall, haz);
    check("pc_write", pc_write, exp_pw);
    check("if_id_write", if_id_write, exp_pw);
    if (r) begin
      m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_chk = 1'b1; m_cnt = '0;
    end else if (!fz) begin
      m_data = idd;
      if (fl || haz) begin
        m_valid = 1'b0; m_ctrl = '0; m_chk = 1'b0;
        if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_valid = 1'b1; m_ctrl = id_ctrl; m_chk = 1'b1;
      end
    end
    e.valid = m_valid; e.ctrl = m_ctrl; e.data = m_data; e.chk = m_chk; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      got_ctrl = {ex_reg_dst, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_mem_read,
                  ex_mem_write, ex_operation};
      got_data = {ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd};
      check("ex_valid", ex_valid, e.valid);
      check("ex_ctrl", got_ctrl, e.ctrl);
      if (e.chk) check("ex_data", got_data, e.data);
      check("stall_count", stall_count, e.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    set_id(11'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_chk = 1'b1; m_cnt = '0;

    // reset state
    set_id(C_ADD, 5'd3, 5'd4, 5'd5);
    step(1'b1, 1'b0, 1'b0);

    // lw to $zero followed by a $zero reader: no stall
    set_id(C_LW, 5'd1, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_ADD, 5'd0, 5'd2, 5'd3);
    step(1'b0, 1'b0, 1'b0);

    // lw $5 then add using $5: one bubble, then the add loads
    set_id(C_LW, 5'd1, 5'd5, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_ADD, 5'd5, 5'd6, 5'd7);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // flush squashes writes
    set_id(C_RWW, 5'd1, 5'd2, 5'd3);
    step(1'b0, 1'b1, 1'b0);

    // freeze holds for three cycles of changing input, then freeze with a hazard
    set_id(C_LW, 5'd2, 5'd8, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_id(11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step(1'b0, 1'b0, 1'b1);
    end
    set_id(C_ADD, 5'd8, 5'd1, 5'd9);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // mixed random traffic on a small register range
    for (int i = 0; i < 24; i++) begin
      set_id(11'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      step(1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

`ifdef HAZARD_DETECT_EN
    // preload the counter near saturation while the stage is frozen
    @(negedge clk);
    freeze = 1'b1;
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    m_cnt = 16'hFFFE;
`endif
    set_id(C_LW, 5'd1, 5'd9, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_ADD, 5'd9, 5'd2, 5'd3);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_LW, 5'd1, 5'd9, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_ADD, 5'd2, 5'd9, 5'd3);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // reset during a hazard overrides
    set_id(C_LW, 5'd1, 5'd10, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    set_id(C_ADD, 5'd10, 5'd2, 5'd3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
